// File: rtl/numpy_to_polyphony_polyphony_lib_complex_acc_pkg.sv
// Shared definitions for the complex multiply/accumulate library stages:
// accumulator states, lane slice macros and a count-width helper.
`ifndef NUMPY_TO_POLYPHONY_POLYPHONY_LIB_MACROS
`define NUMPY_TO_POLYPHONY_POLYPHONY_LIB_MACROS
`define REAL(x) (x[2*BIT-1:BIT])
`define IMAG(x) (x[BIT-1:0])
`endif

package numpy_to_polyphony_polyphony_lib_complex_acc_pkg;

    typedef enum logic {
        ACC_ACCUM  = 1'b0,
        ACC_FINISH = 1'b1
    } acc_state_t;

    // One extra bit beyond clog2 keeps LEN=1 at a legal 1-bit counter.
    function automatic int cnt_width(input int len);
        return $clog2(len) + 1;
    endfunction

endpackage

// File: rtl/numpy_to_polyphony_polyphony_lib_sat_trunc.sv
// Combinational signed saturation from IN_W down to OUT_W bits, with a clamp flag.
module numpy_to_polyphony_polyphony_lib_sat_trunc #(
    parameter int IN_W  = 40,
    parameter int OUT_W = 32
) (
    input  logic signed [IN_W-1:0]  in,
    output logic signed [OUT_W-1:0] out,
    output logic                    ovf
);

    localparam int HEAD_W = IN_W - OUT_W + 1;
    localparam logic [OUT_W-1:0] SAT_HI = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_LO = {1'b1, {(OUT_W-1){1'b0}}};

    // Value fits when every bit above the output sign bit matches that sign bit.
    function automatic logic [OUT_W:0] sat_fn(input logic signed [IN_W-1:0] v);
        logic [HEAD_W-1:0] head;
        head = v[IN_W-1:OUT_W-1];
        if (head == {HEAD_W{1'b0}} || head == {HEAD_W{1'b1}})
            return {1'b0, v[OUT_W-1:0]};
        else if (v[IN_W-1])
            return {1'b1, SAT_LO};
        else
            return {1'b1, SAT_HI};
    endfunction

    assign {ovf, out} = sat_fn(in);

endmodule

// File: rtl/numpy_to_polyphony_polyphony_lib_complex_acc.sv
// Complex accumulator: sums LEN complex products per lane in guarded registers,
// then presents one saturated complex result held until downstream accepts it.
module numpy_to_polyphony_polyphony_lib_complex_acc
    import numpy_to_polyphony_polyphony_lib_complex_acc_pkg::*;
#(
    parameter int BIT       = 32,
    parameter int PRECISION = 16,
    parameter int LEN       = 8,
    parameter int GUARD     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             acc_ready,
    output logic             acc_taken,
    input  logic [2*BIT-1:0] acc_in,
    output logic             acc_valid,
    input  logic             acc_accept,
    output logic [2*BIT-1:0] acc_out_0,
    output logic             acc_ovf
);

    localparam int ACC_W = BIT + GUARD;
    localparam int CNT_W = cnt_width(LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

    // Products arrive already in the output Q format, so no rescale is applied.
    if (LEN < 1 || LEN > 256 || PRECISION < 0 || PRECISION >= BIT || GUARD < $clog2(LEN)) begin : g_bad_cfg
        $error("complex_acc: illegal LEN/PRECISION/GUARD combination");
    end

    acc_state_t              state;
    logic [CNT_W-1:0]        cnt;
    logic signed [ACC_W-1:0] sum_re, sum_im;
    logic signed [ACC_W-1:0] sum_re_nx, sum_im_nx;
    logic signed [BIT-1:0]   in_re, in_im;
    logic signed [BIT-1:0]   sat_re, sat_im;
    logic                    ovf_re, ovf_im;
    logic                    last;
    logic [2*BIT-1:0]        out_p1;
    logic                    ovf_p1;
    logic                    vld_p1;

    assign in_re     = `REAL(acc_in);
    assign in_im     = `IMAG(acc_in);
    assign sum_re_nx = sum_re + ACC_W'(in_re);
    assign sum_im_nx = sum_im + ACC_W'(in_im);

    assign acc_taken = (state == ACC_ACCUM) && acc_ready;
    assign last      = acc_taken && (cnt == CNT_LAST);

    // Saturation sees the sums including the sample taken this cycle.
    numpy_to_polyphony_polyphony_lib_sat_trunc #(
        .IN_W  (ACC_W),
        .OUT_W (BIT)
    ) u_sat_re (
        .in  (sum_re_nx),
        .out (sat_re),
        .ovf (ovf_re)
    );

    numpy_to_polyphony_polyphony_lib_sat_trunc #(
        .IN_W  (ACC_W),
        .OUT_W (BIT)
    ) u_sat_im (
        .in  (sum_im_nx),
        .out (sat_im),
        .ovf (ovf_im)
    );

    // Stage p0 -> p1: accumulate, then register the saturated result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ACC_ACCUM;
            cnt    <= '0;
            sum_re <= '0;
            sum_im <= '0;
            out_p1 <= '0;
            ovf_p1 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            case (state)
                ACC_ACCUM: begin
                    if (last) begin
                        out_p1 <= {sat_re, sat_im};
                        ovf_p1 <= ovf_re | ovf_im;
                        vld_p1 <= 1'b1;
                        sum_re <= '0;
                        sum_im <= '0;
                        cnt    <= '0;
                        state  <= ACC_FINISH;
                    end else if (acc_taken) begin
                        sum_re <= sum_re_nx;
                        sum_im <= sum_im_nx;
                        cnt    <= cnt + CNT_W'(1);
                    end
                end
                ACC_FINISH: begin
                    if (acc_accept) begin
                        vld_p1 <= 1'b0;
                        state  <= ACC_ACCUM;
                    end
                end
                default: state <= ACC_ACCUM;
            endcase
        end
    end

    assign acc_out_0 = out_p1;
    assign acc_ovf   = ovf_p1;
    assign acc_valid = vld_p1;

endmodule
